// File: rtl/fft_pkg.sv
// Shared constants and elaboration-time helpers for the FFT datapath.
package fft_pkg;

   localparam int DEF_FFT_N = 64;
   localparam int DEF_W     = 10;
   localparam int DEF_TW_W  = 10;

   localparam real PI = 3.14159265358979323846;

   // Round to nearest, ties away from zero.
   function automatic int round_away(input real x);
      if (x >= 0.0) return $rtoi($floor(x + 0.5));
      else          return -$rtoi($floor(-x + 0.5));
   endfunction

   // C = round(S * cos(2*pi*e/n)), S = 2^(tw_w-2).
   function automatic int tw_cos(input int e, input int n, input int tw_w);
      return round_away(real'(1 << (tw_w - 2)) * $cos(2.0 * PI * real'(e) / real'(n)));
   endfunction

   // D = round(S * sin(2*pi*e/n)).
   function automatic int tw_sin(input int e, input int n, input int tw_w);
      return round_away(real'(1 << (tw_w - 2)) * $sin(2.0 * PI * real'(e) / real'(n)));
   endfunction

   // Twiddle exponent for block k, 1-based lane l: (k*l) mod n.
   function automatic int exp_mod(input int k, input int l, input int n);
      return (k * l) % n;
   endfunction

endpackage

// File: rtl/twiddle_lane.sv
// One lane: four real multiplies (S2), then add/sub, round, saturate (S3).
module twiddle_lane #(
   parameter int W    = 10,
   parameter int TW_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_en,
   input  logic signed [W-1:0]    i_re,
   input  logic signed [W-1:0]    i_im,
   input  logic signed [TW_W-1:0] i_c,
   input  logic signed [TW_W-1:0] i_d,
   input  logic                   i_inv,   // inverse flag of the beat in S2
   output logic signed [W-1:0]    o_re,
   output logic signed [W-1:0]    o_im
);

   localparam int PW = W + TW_W;
   localparam int SW = W + TW_W + 1;
   localparam logic signed [SW-1:0] RND   = SW'(1 << (TW_W - 3));
   localparam logic signed [SW-1:0] MAX_V = SW'((1 << (W - 1)) - 1);
   localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);

   logic signed [PW-1:0] r_ac, r_bd, r_ad, r_bc;
   logic signed [SW-1:0] w_pre, w_pim, w_sre, w_sim;
   logic signed [W-1:0]  r_re, r_im;

   function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
      if (x > MAX_V)      return MAX_V[W-1:0];
      else if (x < MIN_V) return MIN_V[W-1:0];
      else                return x[W-1:0];
   endfunction

   // S2: the four partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ac <= '0;
         r_bd <= '0;
         r_ad <= '0;
         r_bc <= '0;
      end else if (i_en) begin
         r_ac <= PW'(i_re) * PW'(i_c);
         r_bd <= PW'(i_im) * PW'(i_d);
         r_ad <= PW'(i_re) * PW'(i_d);
         r_bc <= PW'(i_im) * PW'(i_c);
      end
   end

   // Combine products; forward uses C - jD, inverse uses C + jD.
   // NOTE: every output gets a default before the branch so no latch is inferred.
   always_comb begin
      w_pre = '0;
      w_pim = '0;
      if (i_inv) begin
         w_pre = SW'(r_ac) - SW'(r_bd);
         w_pim = SW'(r_ad) + SW'(r_bc);
      end else begin
         w_pre = SW'(r_ac) + SW'(r_bd);
         w_pim = SW'(r_bc) - SW'(r_ad);
      end
      w_sre = (w_pre + RND) >>> (TW_W - 2);
      w_sim = (w_pim + RND) >>> (TW_W - 2);
   end

   // S3: registered rounded and saturated result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_re <= '0;
         r_im <= '0;
      end else if (i_en) begin
         r_re <= sat(w_sre);
         r_im <= sat(w_sim);
      end
   end

   assign o_re = r_re;
   assign o_im = r_im;

endmodule

// File: rtl/twiddle_rom.sv
// Twiddle table {C, D} with one registered read port per lane.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter  int FFT_N = DEF_FFT_N,
   parameter  int TW_W  = DEF_TW_W,
   parameter  int PORTS = 7,
   localparam int AW    = $clog2(FFT_N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [PORTS*AW-1:0]   i_addr,
   output logic [PORTS*TW_W-1:0] o_c,
   output logic [PORTS*TW_W-1:0] o_d
);

   logic signed [TW_W-1:0] w_tab_c [FFT_N];
   logic signed [TW_W-1:0] w_tab_d [FFT_N];
   logic [PORTS-1:0][TW_W-1:0] r_c;
   logic [PORTS-1:0][TW_W-1:0] r_d;

   // Table contents are constants folded at elaboration.
   for (genvar e = 0; e < FFT_N; e++) begin : g_tab
      assign w_tab_c[e] = TW_W'(tw_cos(e, FFT_N, TW_W));
      assign w_tab_d[e] = TW_W'(tw_sin(e, FFT_N, TW_W));
   end

   // Registered lookup per port; holds while the pipeline is stalled.
   // NOTE: the table itself is constant logic and needs no reset; only the
   // read registers are state, and they use non-blocking assignments so every
   // port samples the pre-edge address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c <= '0;
         r_d <= '0;
      end else if (i_en) begin
         for (int p = 0; p < PORTS; p++) begin
            r_c[p] <= w_tab_c[i_addr[p*AW +: AW]];
            r_d[p] <= w_tab_d[i_addr[p*AW +: AW]];
         end
      end
   end

   assign o_c = r_c;
   assign o_d = r_d;

endmodule

// File: rtl/twiddle_mul_pipe.sv
// Three-stage pipelined complex twiddle multiplier with valid/ready flow control.
module twiddle_mul_pipe
   import fft_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int TW_W  = DEF_TW_W,
   parameter int LANES = 7,
   parameter int FFT_N = DEF_FFT_N,
   parameter int KW    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_re,
   input  logic [LANES*W-1:0] in_im,
   input  logic [KW-1:0]      in_k,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] out_re,
   output logic [LANES*W-1:0] out_im,
   output logic [KW-1:0]      out_k
);

   localparam int AW = $clog2(FFT_N);

   logic                     w_en;
   logic [LANES*AW-1:0]      w_addr;
   logic [LANES*TW_W-1:0]    w_c, w_d;
   logic                     r1_valid, r2_valid, r3_valid;
   logic [KW-1:0]            r1_k, r2_k, r3_k;
   logic                     r1_inv, r2_inv;
   logic [LANES*W-1:0]       r1_re, r1_im;

   // The whole pipeline advances together unless the output is held.
   assign w_en      = !r3_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r3_valid;
   assign out_k     = r3_k;

   // Table address per lane from the incoming block index.
   always_comb begin
      w_addr = '0;
      for (int l = 0; l < LANES; l++)
         w_addr[l*AW +: AW] = AW'(exp_mod(int'(in_k), l + 1, FFT_N));
   end

   twiddle_rom #(
      .FFT_N (FFT_N),
      .TW_W  (TW_W),
      .PORTS (LANES)
   ) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_addr (w_addr),
      .o_c    (w_c),
      .o_d    (w_d)
   );

   // Control and S1 sample pipeline; bubbles travel as invalid stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r2_valid <= 1'b0;
         r3_valid <= 1'b0;
         r1_k     <= '0;
         r2_k     <= '0;
         r3_k     <= '0;
         r1_inv   <= 1'b0;
         r2_inv   <= 1'b0;
         r1_re    <= '0;
         r1_im    <= '0;
      end else if (w_en) begin
         r1_valid <= in_valid;
         r2_valid <= r1_valid;
         r3_valid <= r2_valid;
         r1_k     <= in_k;
         r2_k     <= r1_k;
         r3_k     <= r2_k;
         r1_inv   <= in_inv;
         r2_inv   <= r1_inv;
         r1_re    <= in_re;
         r1_im    <= in_im;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      twiddle_lane #(
         .W    (W),
         .TW_W (TW_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (w_en),
         .i_re  (r1_re[l*W +: W]),
         .i_im  (r1_im[l*W +: W]),
         .i_c   (w_c[l*TW_W +: TW_W]),
         .i_d   (w_d[l*TW_W +: TW_W]),
         .i_inv (r2_inv),
         .o_re  (out_re[l*W +: W]),
         .o_im  (out_im[l*W +: W])
      );
   end

endmodule

// File: tb/tb_twiddle_mul_pipe.sv
// Directed bench for twiddle_mul_pipe: reset, per-lane products, saturation,
// streaming with and without backpressure, reset with beats in flight.
module tb_twiddle_mul_pipe;

   localparam int W     = 10;
   localparam int TW_W  = 10;
   localparam int LANES = 7;
   localparam int KW    = 3;

   // Hand-derived table for N=64, S=256, e = 0..14.
   localparam int TB_C [15] = '{256, 255, 251, 245, 237, 226, 213, 198, 181, 162, 142, 121, 98, 74, 50};
   localparam int TB_D [15] = '{0, 25, 50, 74, 98, 121, 142, 162, 181, 198, 213, 226, 237, 245, 251};

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid, in_ready, in_inv, out_valid, out_ready;
   logic [LANES*W-1:0] in_re, in_im, out_re, out_im;
   logic [KW-1:0]      in_k, out_k;
   logic               in_ready_32, out_valid_32;
   logic [LANES*W-1:0] out_re_32, out_im_32;
   logic [KW-1:0]      out_k_32;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   twiddle_mul_pipe #(.W(W), .TW_W(TW_W), .LANES(LANES), .FFT_N(64), .KW(KW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_k(in_k), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_k(out_k)
   );

   twiddle_mul_pipe #(.W(W), .TW_W(TW_W), .LANES(LANES), .FFT_N(32), .KW(KW)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_32),
      .in_re(in_re), .in_im(in_im), .in_k(in_k), .in_inv(in_inv),
      .out_valid(out_valid_32), .out_ready(out_ready),
      .out_re(out_re_32), .out_im(out_im_32), .out_k(out_k_32)
   );

   function automatic int lane_of(input logic [LANES*W-1:0] v, input int l);
      logic signed [W-1:0] s;
      s = v[(l-1)*W +: W];
      return int'(s);
   endfunction

   // Spec formula: P_re = a*C - b*t, P_im = a*t + b*C, t = -D or +D.
   function automatic int model(input int a, input int b, input int e, input bit inv, input bit im_part);
      longint c, t, p;
      c = TB_C[e];
      t = inv ? TB_D[e] : -TB_D[e];
      p = im_part ? (a * t + b * c) : (a * c - b * t);
      p = (p + 128) >>> 8;
      if (p > 511)  p = 511;
      if (p < -512) p = -512;
      return int'(p);
   endfunction

   function automatic int st_re(input int i);  return 100 - 13 * i; endfunction
   function automatic int st_im(input int i);  return 7 * i - 60;   endfunction
   function automatic bit st_inv(input int i); return (i % 3) == 0; endfunction

   task automatic drive_all(input int re, input int im, input int k, input bit inv);
      logic [W-1:0] r, m;
      r = W'(re);
      m = W'(im);
      for (int l = 0; l < LANES; l++) begin
         in_re[l*W +: W] = r;
         in_im[l*W +: W] = m;
      end
      in_k   = KW'(k);
      in_inv = inv;
   endtask

   // Sends one beat with out_ready high; lat = edges until out_valid (0 = timeout).
   task automatic send_one(input int re, input int im, input int k, input bit inv, output int lat);
      @(posedge clk); #1;
      drive_all(re, im, k, inv);
      in_valid = 1'b1;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s out_valid: got %b want 0", tag, out_valid); end
      n_vec++; if (out_re !== '0) begin n_err++; $display("FAIL %s out_re: got %h want 0", tag, out_re); end
      n_vec++; if (out_im !== '0) begin n_err++; $display("FAIL %s out_im: got %h want 0", tag, out_im); end
      n_vec++; if (out_k !== '0) begin n_err++; $display("FAIL %s out_k: got %0d want 0", tag, out_k); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive_all(0, 0, 0, 1'b0);
      #1;
      check_idle_outputs("reset_asserted");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check_idle_outputs("reset_released");
   endtask

   // Checks all lanes of one beat against hand tables.
   task automatic test_lanes(input string tag, input int re, input int im, input int k, input bit inv,
                             input int er [LANES], input int ei [LANES]);
      int lat;
      send_one(re, im, k, inv, lat);
      n_vec++;
      if (lat != 3) begin n_err++; $display("FAIL %s latency: got %0d want 3", tag, lat); end
      n_vec++;
      if (out_k !== KW'(k)) begin n_err++; $display("FAIL %s out_k: got %0d want %0d", tag, out_k, k); end
      for (int l = 1; l <= LANES; l++) begin
         n_vec++;
         if (lane_of(out_re, l) !== er[l-1]) begin
            n_err++; $display("FAIL %s lane%0d re: got %0d want %0d", tag, l, lane_of(out_re, l), er[l-1]);
         end
         n_vec++;
         if (lane_of(out_im, l) !== ei[l-1]) begin
            n_err++; $display("FAIL %s lane%0d im: got %0d want %0d", tag, l, lane_of(out_im, l), ei[l-1]);
         end
      end
   endtask

   task automatic test_directed();
      test_lanes("k0_fwd", 100, 0, 0, 1'b0, '{100, 100, 100, 100, 100, 100, 100}, '{0, 0, 0, 0, 0, 0, 0});
      test_lanes("k1_fwd", 100, 0, 1, 1'b0, '{100, 98, 96, 93, 88, 83, 77}, '{-10, -20, -29, -38, -47, -55, -63});
      test_lanes("k2_inv", 100, 0, 2, 1'b1, '{98, 93, 83, 71, 55, 38, 20}, '{20, 38, 55, 71, 83, 93, 98});
      test_lanes("k4_inv", 100, 0, 4, 1'b1, '{93, 71, 38, 0, -38, -71, -93}, '{38, 71, 93, 100, 93, 71, 38});
   endtask

   task automatic test_forward_k4();
      int lat;
      send_one(100, 0, 4, 1'b0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL k4_fwd latency: got %0d want 3", lat); end
      n_vec++; if (lane_of(out_re, 4) !== 0) begin n_err++; $display("FAIL k4_fwd lane4 re: got %0d want 0", lane_of(out_re, 4)); end
      n_vec++; if (lane_of(out_im, 4) !== -100) begin n_err++; $display("FAIL k4_fwd lane4 im: got %0d want -100", lane_of(out_im, 4)); end
      n_vec++; if (lane_of(out_im, 2) !== -71) begin n_err++; $display("FAIL k4_fwd lane2 im: got %0d want -71", lane_of(out_im, 2)); end
   endtask

   task automatic test_saturation();
      int lat;
      // e=8 forward, 511+j511 rotated by -45 deg: magnitude exceeds range.
      send_one(511, 511, 2, 1'b0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL sat_pos latency: got %0d want 3", lat); end
      n_vec++; if (lane_of(out_re, 4) !== 511) begin n_err++; $display("FAIL sat_pos lane4 re: got %0d want 511", lane_of(out_re, 4)); end
      n_vec++; if (lane_of(out_im, 4) !== 0) begin n_err++; $display("FAIL sat_pos lane4 im: got %0d want 0", lane_of(out_im, 4)); end
      send_one(-512, -512, 2, 1'b0, lat);
      n_vec++; if (lane_of(out_re, 4) !== -512) begin n_err++; $display("FAIL sat_neg lane4 re: got %0d want -512", lane_of(out_re, 4)); end
      n_vec++; if (lane_of(out_im, 4) !== 0) begin n_err++; $display("FAIL sat_neg lane4 im: got %0d want 0", lane_of(out_im, 4)); end
      // N=32 build: k=4 lane 4 gives e=N/2, C=-256; -512*-256 saturates to 511.
      send_one(-512, 0, 4, 1'b0, lat);
      n_vec++; if (out_valid_32 !== 1'b1) begin n_err++; $display("FAIL sat_n32 out_valid: got %b want 1", out_valid_32); end
      n_vec++; if (out_k_32 !== 3'd4) begin n_err++; $display("FAIL sat_n32 out_k: got %0d want 4", out_k_32); end
      n_vec++; if (lane_of(out_re_32, 4) !== 511) begin n_err++; $display("FAIL sat_n32 lane4 re: got %0d want 511", lane_of(out_re_32, 4)); end
      n_vec++; if (lane_of(out_im_32, 4) !== 0) begin n_err++; $display("FAIL sat_n32 lane4 im: got %0d want 0", lane_of(out_im_32, 4)); end
   endtask

   // 20-beat stream; with stall=1 out_ready toggles and held outputs are
   // re-checked against the same expected beat every stalled cycle.
   task automatic test_stream(input bit stall, input string tag);
      int sent = 0, got = 0, cyc = 0;
      bit in_x, out_x;
      @(posedge clk); #1;
      while ((got < 20) && (cyc < 400)) begin
         out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (sent < 20) begin
            drive_all(st_re(sent), st_im(sent), sent % 8, st_inv(sent));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!stall) begin
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); end
         end
         if (out_valid === 1'b1) begin
            n_vec++;
            if (out_k !== KW'(got % 8)) begin n_err++; $display("FAIL %s beat%0d out_k: got %0d want %0d", tag, got, out_k, got % 8); end
            for (int l = 1; l <= 2; l++) begin
               int e, xr, xi;
               e  = (got % 8) * l;
               xr = model(st_re(got), st_im(got), e, st_inv(got), 1'b0);
               xi = model(st_re(got), st_im(got), e, st_inv(got), 1'b1);
               n_vec++;
               if (lane_of(out_re, l) !== xr) begin n_err++; $display("FAIL %s beat%0d lane%0d re: got %0d want %0d", tag, got, l, lane_of(out_re, l), xr); end
               n_vec++;
               if (lane_of(out_im, l) !== xi) begin n_err++; $display("FAIL %s beat%0d lane%0d im: got %0d want %0d", tag, got, l, lane_of(out_im, l), xi); end
            end
         end
         in_x  = in_valid && in_ready;
         out_x = (out_valid === 1'b1) && out_ready;
         @(posedge clk); #1;
         if (in_x)  sent++;
         if (out_x) got++;
         cyc++;
      end
      n_vec++;
      if (got != 20) begin n_err++; $display("FAIL %s beats out: got %0d want 20 (cycle budget)", tag, got); end
      if (!stall) begin
         n_vec++;
         if (cyc != 23) begin n_err++; $display("FAIL %s throughput cycles: got %0d want 23", tag, cyc); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s extra beat: out_valid got %b want 0", tag, out_valid); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         drive_all(50, 50, 5 + i, 1'b0);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst pre out_valid: got %b want 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst_asserted");
      @(posedge clk); #1;
      check_idle_outputs("midrst_held");
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      send_one(100, 0, 1, 1'b0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL midrst first latency: got %0d want 3", lat); end
      n_vec++; if (out_k !== 3'd1) begin n_err++; $display("FAIL midrst first out_k: got %0d want 1", out_k); end
      n_vec++; if (lane_of(out_re, 1) !== 100) begin n_err++; $display("FAIL midrst lane1 re: got %0d want 100", lane_of(out_re, 1)); end
      n_vec++; if (lane_of(out_im, 1) !== -10) begin n_err++; $display("FAIL midrst lane1 im: got %0d want -10", lane_of(out_im, 1)); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_forward_k4();
      test_saturation();
      test_stream(1'b0, "stream_free");
      test_stream(1'b1, "stream_stall");
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/twiddle_mul_pipe.md
# twiddle_mul_pipe

Parametrised, pipelined complex twiddle multiplier for the 64-point FFT datapath, successor to the fixed 7-lane combinational multiplier. Each accepted beat carries LANES complex samples and a block index k; lane l (1-based) is multiplied by W_N^(k·l), or its conjugate in inverse mode, with rounding and saturation. It sits between the radix-8 butterfly stage and the next butterfly stage, with valid/ready flow control on both sides.

## Interface
- W, 10, signed sample width (real and imaginary parts)
- TW_W, 10, signed twiddle width; format Q1.(TW_W-2), scale S = 2^(TW_W-2)
- LANES, 7, complex lanes per beat
- FFT_N, 64, transform size; power of two, ≥ 8
- KW, 3, width of block index k
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_re  in  LANES·W  real parts; lane 1 in bits [W-1:0], lane l in [l·W-1:(l-1)·W]
- in_im  in  LANES·W  imaginary parts, same packing
- in_k  in  KW  block index k
- in_inv  in  1  1 = use conjugate twiddle (inverse FFT)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_re, out_im  out  LANES·W  products, same packing
- out_k  out  KW  in_k of the beat, passed through

## Operation
- Twiddle for lane l: e = (k·l) mod FFT_N; C = round(S·cos(2πe/FFT_N)), D = round(S·sin(2πe/FFT_N)); twiddle = C − jD (forward) or C + jD (in_inv=1).
- Rounding of table entries is to nearest, ties away from zero; cos(0) stored as exactly S (representable, since S < 2^(TW_W-1)).
- Product per lane, with a = re, b = im, t_im = ∓D: P_re = a·C − b·t_im, P_im = a·t_im + b·C, computed at full width W+TW_W+1.
- Scaling: out = (P + 2^(TW_W-3)) >>> (TW_W-2) (arithmetic shift, round half up), then saturate to [−2^(W-1), 2^(W-1)−1].
- Transfer on in_valid && in_ready at input; transfer on out_valid && out_ready at output.
- out_k is the in_k of the same beat; beat order is preserved, no reordering or drops.

## Timing
- Three pipeline stages: S1 exponent computation and twiddle table lookup (registered); S2 four real multiplies (registered); S3 add/sub, round and saturate (registered, drives outputs).
- Latency: accepted at edge n → out_valid at edge n+3 when unstalled.
- Global advance enable en = !out_valid || out_ready; in_ready = en (combinational from out_ready).
- When en = 0, all stage registers hold, including data and valid; outputs stay stable while out_valid && !out_ready.
- Full throughput: one beat per cycle with out_ready held high.
- Bubbles propagate as invalid stages and are not collapsed.
- Reset (async assert, sync-released deassert by the system): every stage valid = 0, all data registers = 0. Outputs during reset: out_valid = 0, out_re/out_im/out_k = 0, in_ready = 1.
- Reset mid-operation discards all in-flight beats; no partial output is produced.
- Simultaneous input and output transfer in one cycle is legal and is the steady state.

## Structure
- Shared package fft_pkg: FFT_N, W, TW_W defaults; constant function for twiddle C/D computation; the exponent-mod helper.
- Sub-module twiddle_rom (FFT_N entries of {C, D}) holds the table. Contents are generated at elaboration from the package function, with one synchronous read port per lane. LANES instances, or one multi-port instance.
- A per-lane complex multiply/round/saturate datapath is instantiated LANES times in a generate loop inside twiddle_mul_pipe.

## Test plan
- All lanes re=100, im=0, k=0, forward → after 3 cycles all lanes out 100+j0; out_k=0.
- re=100, im=0, k=1: lane 1 (e=1, C=255, D=25) → 100 − j10; lane 2 (e=2, C=251, D=50) → 98 − j20.
- re=100, im=0, k=2, in_inv=1: lane 8 is not present; lane 4 (e=8, C=D=181) → 71 + j71; lane 16-step check uses k=4: lane 4 (e=16) → 0 + j100.
- Saturation: re=−512, im=0, k=4: lane 8 absent; use lane 8 of LANES=8 build or k=4 lane 4 with FFT_N=32 build → e=FFT_N/2, expect +511 (saturated), im 0.
- Backpressure: stream 20 beats with k = beat index mod 8 while out_ready toggles pseudo-randomly. Expect identical output sequence to the unstalled run, no loss or duplication, and outputs held stable while stalled.
- Assert rst_n low with 3 beats in flight → out_valid=0 immediately; after release the first output is the first beat sent after reset.
